// File: rtl/pim_pkg.sv
// Shared PIM definitions: packet width, input-buffer sizing defaults and
// bit positions of the controller status register.
package pim_pkg;

    localparam int PIM_PACKET_WIDTH = 32;
    localparam int IPBUF_DEPTH      = 16;
    localparam int IPBUF_AFULL_LVL  = 12;

    localparam int IPBUF_STAT_W = 5;

    typedef enum logic [2:0] {
        STAT_FULL  = 3'd0,
        STAT_AFULL = 3'd1,
        STAT_EMPTY = 3'd2,
        STAT_OVF   = 3'd3,
        STAT_UDF   = 3'd4
    } ipbuf_stat_idx_e;

    // Packs buffer flags into the controller status word; bit order follows ipbuf_stat_idx_e.
    function automatic logic [IPBUF_STAT_W-1:0] ipbuf_status_pack(
        input logic full,
        input logic afull,
        input logic empty,
        input logic ovf,
        input logic udf
    );
        return {udf, ovf, empty, afull, full};
    endfunction

endpackage

// File: rtl/ipbuf_mem.sv
// Register-array storage for the input packet buffer: one synchronous write
// port and one asynchronous read port. Contents are never cleared.
module ipbuf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/ipbuf_fifo.sv
// Input packet buffer feeding the MAC core: first-word-fall-through FIFO with
// registered occupancy, almost-full and sticky overflow/underflow status.
module ipbuf_fifo
    import pim_pkg::*;
#(
    parameter int PACKET_WIDTH = PIM_PACKET_WIDTH,
    parameter int DEPTH        = IPBUF_DEPTH,
    parameter int AFULL_LVL    = IPBUF_AFULL_LVL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rst_work,
    input  logic                      wen,
    input  logic [PACKET_WIDTH-1:0]   wdata,
    output logic                      full,
    output logic                      almost_full,
    output logic                      ipbuf_empty,
    input  logic                      ren_to_ipbuf,
    output logic [PACKET_WIDTH-1:0]   data_out,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_CNT = (AW+1)'(AFULL_LVL);

    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [AW:0]             count_next_s;
    logic                    wr_ok_s;
    logic                    pop_ok_s;
    logic                    clear_s;
    logic [PACKET_WIDTH-1:0] head_s;

    assign clear_s = rst | rst_work;

    ipbuf_mem #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok_s & ~clear_s),
        .waddr (wr_ptr_r),
        .wdata (wdata),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Acceptance and next occupancy; a pop from a full buffer frees the slot for a same-cycle write.
    always_comb begin
        pop_ok_s     = 1'b0;
        wr_ok_s      = 1'b0;
        count_next_s = count;
        pop_ok_s     = ren_to_ipbuf & ~ipbuf_empty;
        wr_ok_s      = wen & (~full | pop_ok_s);
        if (wr_ok_s && !pop_ok_s) begin
            count_next_s = count + CNT_ONE;
        end else if (!wr_ok_s && pop_ok_s) begin
            count_next_s = count - CNT_ONE;
        end else begin
            count_next_s = count;
        end
    end

    // Pointers, occupancy and status flags; flags are derived from the next count.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count       <= CNT_ZERO;
            full        <= 1'b0;
            almost_full <= 1'b0;
            ipbuf_empty <= 1'b1;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count       <= count_next_s;
            full        <= (count_next_s == FULL_CNT);
            almost_full <= (count_next_s >= AFULL_CNT);
            ipbuf_empty <= (count_next_s == CNT_ZERO);
            if (wen && !wr_ok_s) begin
                overflow <= 1'b1;
            end
            if (ren_to_ipbuf && ipbuf_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Head word is masked while empty so the MAC never sees stale storage.
    always_comb begin
        data_out = {PACKET_WIDTH{1'b0}};
        if (!ipbuf_empty) begin
            data_out = head_s;
        end else begin
            data_out = {PACKET_WIDTH{1'b0}};
        end
    end

endmodule
